// File: rtl/dadda_pkg.sv
// Shared definitions for the Dadda multiplier and the multiply-accumulate stage.
//   OP_W        operand width of the multiplier
//   PROD_W      product width of the multiplier
//   mac_state_t accumulator control states
package dadda_pkg;

    localparam int unsigned OP_W   = 8;
    localparam int unsigned PROD_W = 16;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } mac_state_t;

endpackage

// File: rtl/dadda_8bit_structural.sv
// Unsigned 8x8 multiplier built as a Dadda-style carry-save reduction tree.
// The eight partial-product rows are reduced with 3:2 compressors through the
// height sequence 8 -> 6 -> 4 -> 3 -> 2, then a single carry-propagate adder
// resolves the last two rows.
// Ports:
//   a_i, b_i  unsigned operands
//   product   a_i * b_i
//   P_sum     final sum row of the reduction tree
//   P_carry   final carry row of the reduction tree
//   carry     carry out of the final adder (always 0 for in-range operands)
module dadda_8bit_structural
    import dadda_pkg::*;
(
    input  logic [OP_W-1:0]   a_i,
    input  logic [OP_W-1:0]   b_i,
    output logic [PROD_W-1:0] product,
    output logic [PROD_W-1:0] P_sum,
    output logic [PROD_W-1:0] P_carry,
    output logic              carry
);

    function automatic logic [PROD_W-1:0] csa_sum(input logic [PROD_W-1:0] x,
                                                  input logic [PROD_W-1:0] y,
                                                  input logic [PROD_W-1:0] z);
        return x ^ y ^ z;
    endfunction

    // Carries beyond bit PROD_W-1 are dropped; arithmetic stays exact modulo
    // 2^PROD_W and the true product always fits.
    function automatic logic [PROD_W-1:0] csa_carry(input logic [PROD_W-1:0] x,
                                                    input logic [PROD_W-1:0] y,
                                                    input logic [PROD_W-1:0] z);
        return ((x & y) | (x & z) | (y & z)) << 1;
    endfunction

    logic [PROD_W-1:0] pp [OP_W];

    for (genvar i = 0; i < OP_W; i++) begin : g_pp
        assign pp[i] = {{(PROD_W-OP_W){1'b0}}, a_i & {OP_W{b_i[i]}}} << i;
    end

    // Height 8 -> 6
    logic [PROD_W-1:0] s1a, c1a, s1b, c1b;
    assign s1a = csa_sum(pp[0], pp[1], pp[2]);
    assign c1a = csa_carry(pp[0], pp[1], pp[2]);
    assign s1b = csa_sum(pp[3], pp[4], pp[5]);
    assign c1b = csa_carry(pp[3], pp[4], pp[5]);

    // Height 6 -> 4
    logic [PROD_W-1:0] s2a, c2a, s2b, c2b;
    assign s2a = csa_sum(s1a, c1a, s1b);
    assign c2a = csa_carry(s1a, c1a, s1b);
    assign s2b = csa_sum(c1b, pp[6], pp[7]);
    assign c2b = csa_carry(c1b, pp[6], pp[7]);

    // Height 4 -> 3
    logic [PROD_W-1:0] s3, c3;
    assign s3 = csa_sum(s2a, c2a, s2b);
    assign c3 = csa_carry(s2a, c2a, s2b);

    // Height 3 -> 2
    logic [PROD_W-1:0] s4, c4;
    assign s4 = csa_sum(s3, c3, c2b);
    assign c4 = csa_carry(s3, c3, c2b);

    logic [PROD_W:0] final_sum;
    assign final_sum = {1'b0, s4} + {1'b0, c4};

    assign P_sum   = s4;
    assign P_carry = c4;
    assign product = final_sum[PROD_W-1:0];
    assign carry   = final_sum[PROD_W];

endmodule

// File: rtl/dadda_mac_accumulator.sv
// Pipelined multiply-accumulate stage. Accepts LEN operand pairs over a
// valid/ready handshake, multiplies each pair with the Dadda multiplier and
// sums the products into an ACC_W-bit accumulator, then presents the result
// over a second valid/ready handshake.
// Pipeline: S1 operand registers -> multiplier -> S2 product register ->
// accumulator. The result appears 3 edges after the LEN-th accept.
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   in_valid, in_ready  operand handshake; a, b sampled on accept
//   out_valid, out_ready result handshake
//   out_acc             final sum, driven only while holding a result
//   overflow            sticky carry out of ACC_W for the current result
// Build option: DADDA_MAC_SAT_EN clamps the accumulator to all ones on carry
// out instead of wrapping.
module dadda_mac_accumulator
    import dadda_pkg::*;
#(
    parameter int unsigned ACC_W = 24,
    parameter int unsigned LEN   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  a,
    input  logic [OP_W-1:0]  b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             overflow
);

    localparam int unsigned CNT_W = $clog2(LEN + 1);
    localparam logic [CNT_W-1:0] LEN_C  = CNT_W'(LEN);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(LEN - 1);
    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

    mac_state_t        state_q;
    logic [OP_W-1:0]   a_q, b_q;
    logic              s1_valid_q;
    logic [PROD_W-1:0] prod_q;
    logic              s2_valid_q;
    logic [ACC_W-1:0]  acc_q;
    logic              ovf_q;
    logic [CNT_W-1:0]  in_cnt_q;
    logic [CNT_W-1:0]  done_cnt_q;
    logic              out_valid_q;
    logic [ACC_W-1:0]  out_acc_q;

    logic [PROD_W-1:0] prod_w;
    logic              accept;
    logic [ACC_W:0]    sum;
    logic [ACC_W-1:0]  acc_add;

    dadda_8bit_structural u_mul (
        .a_i     (a_q),
        .b_i     (b_q),
        .product (prod_w),
        .P_sum   (),
        .P_carry (),
        .carry   ()
    );

    assign in_ready = (state_q == ACCUM) && (in_cnt_q < LEN_C);
    assign accept   = in_valid && in_ready;

    assign sum = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod_q};

`ifdef DADDA_MAC_SAT_EN
    // Once clamped, stay clamped for the remaining items of this result.
    assign acc_add = (sum[ACC_W] || ovf_q) ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
    assign acc_add = sum[ACC_W-1:0];
`endif

    // Operand and product pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q        <= '0;
            b_q        <= '0;
            s1_valid_q <= 1'b0;
            prod_q     <= '0;
            s2_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                a_q <= a;
                b_q <= b;
            end
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                prod_q <= prod_w;
            end
        end
    end

    // Control FSM, counters and accumulator. The HOLD handoff clears state
    // last so it takes precedence over the per-item updates above it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            in_cnt_q    <= '0;
            done_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_acc_q   <= '0;
        end else begin
            if (s2_valid_q) begin
                acc_q      <= acc_add;
                ovf_q      <= ovf_q | sum[ACC_W];
                done_cnt_q <= done_cnt_q + ONE_C;
            end
            if (accept) begin
                in_cnt_q <= in_cnt_q + ONE_C;
            end
            unique case (state_q)
                ACCUM: begin
                    if (accept && (in_cnt_q == LAST_C)) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (done_cnt_q == LEN_C) begin
                        state_q     <= HOLD;
                        out_valid_q <= 1'b1;
                        out_acc_q   <= acc_q;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_q     <= ACCUM;
                        out_valid_q <= 1'b0;
                        out_acc_q   <= '0;
                        acc_q       <= '0;
                        ovf_q       <= 1'b0;
                        in_cnt_q    <= '0;
                        done_cnt_q  <= '0;
                    end
                end
                default: state_q <= ACCUM;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_acc   = out_acc_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_dadda_mac_accumulator.sv
// Self-checking bench for dadda_mac_accumulator. Three instances cover the
// default configuration (24/16), an overflow configuration (20/17) and LEN=1.
module tb_dadda_mac_accumulator;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [2:0]  in_valid;
    logic [2:0]  out_ready;
    logic [7:0]  a, b;

    logic        rdy0, rdy1, rdy2;
    logic        ov0, ov1, ov2;
    logic        of0, of1, of2;
    logic [23:0] acc0;
    logic [19:0] acc1;
    logic [23:0] acc2;

    logic [2:0]  in_ready_w, out_valid_w, ovf_w;
    logic [31:0] acc_w [3];

    assign in_ready_w  = {rdy2, rdy1, rdy0};
    assign out_valid_w = {ov2, ov1, ov0};
    assign ovf_w       = {of2, of1, of0};
    assign acc_w[0]    = {8'd0, acc0};
    assign acc_w[1]    = {12'd0, acc1};
    assign acc_w[2]    = {8'd0, acc2};

    dadda_mac_accumulator #(.ACC_W(24), .LEN(16)) u_full (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(rdy0), .a(a), .b(b),
        .out_valid(ov0), .out_ready(out_ready[0]), .out_acc(acc0), .overflow(of0)
    );

    dadda_mac_accumulator #(.ACC_W(20), .LEN(17)) u_ovf (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(rdy1), .a(a), .b(b),
        .out_valid(ov1), .out_ready(out_ready[1]), .out_acc(acc1), .overflow(of1)
    );

    dadda_mac_accumulator #(.ACC_W(24), .LEN(1)) u_len1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(rdy2), .a(a), .b(b),
        .out_valid(ov2), .out_ready(out_ready[2]), .out_acc(acc2), .overflow(of2)
    );

`ifdef DADDA_MAC_SAT_EN
    localparam logic [31:0] OVF_ACC_EXP = 32'h000F_FFFF;
`else
    localparam logic [31:0] OVF_ACC_EXP = 32'd56849;
`endif

    typedef struct packed {
        logic [31:0] acc;
        logic        ovf;
    } exp_t;

    exp_t sbq [3][$];

    int passed = 0;
    int failed = 0;
    int total  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int s, input logic [31:0] acc, input logic ovf);
        exp_t e;
        e.acc = acc;
        e.ovf = ovf;
        sbq[s].push_back(e);
    endtask

    // Entered at posedge+#1; returns at posedge+#1 after the accept edge.
    task automatic send(input int s, input logic [7:0] av, input logic [7:0] bv,
                        output int stalls, output int acc_cyc);
        bit ok;
        ok      = 1'b0;
        stalls  = 0;
        acc_cyc = 0;
        a = av;
        b = bv;
        in_valid[s] = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (in_ready_w[s]) begin
                ok = 1'b1;
                break;
            end
            stalls++;
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        acc_cyc = int'(cyc);
        in_valid[s] = 1'b0;
        check("send_accepted", {31'd0, ok}, 32'd1);
    endtask

    // Returns at the first negedge where out_valid is high.
    task automatic wait_valid(input int s, output int at_cyc);
        bit ok;
        ok     = 1'b0;
        at_cyc = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (out_valid_w[s]) begin
                ok     = 1'b1;
                at_cyc = int'(cyc);
                break;
            end
        end
        check("out_valid_timeout", {31'd0, ok}, 32'd1);
    endtask

    task automatic realign();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every completed result handshake pops one expectation.
    always @(negedge clk) begin
        for (int s = 0; s < 3; s++) begin
            if (rst_n && out_valid_w[s] && out_ready[s]) begin
                check("sb_has_entry", {31'd0, sbq[s].size() != 0}, 32'd1);
                if (sbq[s].size() != 0) begin
                    exp_t e;
                    e = sbq[s].pop_front();
                    check("result_acc", acc_w[s], e.acc);
                    check("result_ovf", {31'd0, ovf_w[s]}, {31'd0, e.ovf});
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int st, st_sum, c0, c1, t, held;

        in_valid  = 3'b000;
        out_ready = 3'b111;
        a         = 8'd0;
        b         = 8'd0;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        check("reset_in_ready", {31'd0, rdy0}, 32'd1);
        check("reset_out_valid", {31'd0, ov0}, 32'd0);
        check("reset_out_acc", acc_w[0], 32'd0);
        check("reset_overflow", {31'd0, of0}, 32'd0);
        check("reset_in_ready_len1", {31'd0, rdy2}, 32'd1);
        realign();

        // Full range: 16 x 255*255, back to back
        push(0, 32'h000F_E010, 1'b0);
        c0 = 0;
        for (int i = 0; i < 16; i++) send(0, 8'd255, 8'd255, st, c0);
        wait_valid(0, t);
        check("latency_edges", 32'(t - c0), 32'd3);
        realign();

        // Ramp with bubbles: a=0..15, b=2
        push(0, 32'd240, 1'b0);
        st_sum = 0;
        for (int i = 0; i < 16; i++) begin
            send(0, 8'(i), 8'd2, st, c0);
            st_sum += st;
            in_valid[0] = 1'b0;
            realign();
        end
        check("ramp_no_stall", 32'(st_sum), 32'd0);
        wait_valid(0, t);
        realign();

        // Backpressure: result held for 5 cycles
        out_ready[0] = 1'b0;
        push(0, 32'd408, 1'b0);
        for (int i = 0; i < 16; i++) send(0, 8'(i + 1), 8'd3, st, c0);
        wait_valid(0, t);
        held = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (ov0 && !rdy0 && (acc_w[0] == 32'd408)) held++;
        end
        check("backpressure_hold_cycles", 32'(held), 32'd5);
        check("backpressure_acc", acc_w[0], 32'd408);
        check("backpressure_in_ready", {31'd0, rdy0}, 32'd0);
        realign();
        out_ready[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("handoff_out_valid", {31'd0, ov0}, 32'd0);
        check("handoff_in_ready", {31'd0, rdy0}, 32'd1);
        realign();
        push(0, 32'd16, 1'b0);
        for (int i = 0; i < 16; i++) send(0, 8'd1, 8'd1, st, c0);
        wait_valid(0, t);
        realign();

        // Reset mid-stream: partial set discarded
        for (int i = 0; i < 7; i++) send(0, 8'd100, 8'd100, st, c0);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", {31'd0, ov0}, 32'd0);
        check("midrst_out_acc", acc_w[0], 32'd0);
        check("midrst_overflow", {31'd0, of0}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("postrst_in_ready", {31'd0, rdy0}, 32'd1);
        check("postrst_out_valid", {31'd0, ov0}, 32'd0);
        realign();
        push(0, 32'd16, 1'b0);
        for (int i = 0; i < 16; i++) send(0, 8'd1, 8'd1, st, c0);
        wait_valid(0, t);
        realign();

        // Overflow: ACC_W=20, LEN=17, all 255*255
        push(1, OVF_ACC_EXP, 1'b1);
        for (int i = 0; i < 17; i++) send(1, 8'd255, 8'd255, st, c0);
        wait_valid(1, t);
        check("overflow_flag", {31'd0, of1}, 32'd1);
        realign();

        // LEN=1: two results in order, in_ready low until each handoff
        push(2, 32'd15, 1'b0);
        push(2, 32'd63, 1'b0);
        send(2, 8'd3, 8'd5, st, c0);
        send(2, 8'd7, 8'd9, st, c1);
        check("len1_stall_cycles", 32'(st), 32'd4);
        check("len1_accept_spacing", 32'(c1 - c0), 32'd5);
        wait_valid(2, t);
        realign();

        repeat (4) @(posedge clk);
        #1;
        check("sb_drained", 32'(sbq[0].size() + sbq[1].size() + sbq[2].size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
